mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the PSRV32 pipeline. Sits directly downstream of `execute` and consumes its ALU result, store data and destination register. It performs loads and stores over a request/grant/response data-memory port, with byte-lane steering and sign extension, and stalls `execute` while an access is outstanding. It presents a registered MEM/WB bundle to writeback.

## Interface
- DMEM_TIMEOUT, 16: cycles allowed in each of REQ and RESP before the access is aborted as a bus error (≥2).

- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-low reset
- valid_i  in  1  EX result valid
- alu_result_i  in  32  effective address or ALU result
- read_data2_i  in  32  store data
- write_reg_i  in  5  destination register
- memread_i / memwrite_i  in  1  load / store
- funct3_i  in  3  access size and sign
- regwrite_i  in  1  writeback enable
- stall_o  out  1  hold EX outputs
- dmem_req_o  out  1  request
- dmem_we_o  out  1  write
- dmem_addr_o  out  32  word-aligned address
- dmem_wdata_o  out  32  lane-replicated write data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i / dmem_rdata_i  in  1 / 32  read response
- wb_valid_o  out  1  one-cycle MEM/WB valid
- wb_data_o  out  32  load data or ALU result
- write_reg_o  out  5  destination register
- regwrite_o  out  1  writeback enable
- misaligned_o / bus_err_o  out  1  fault flags, qualified by wb_valid_o

## Operation
- FSM states: IDLE, REQ, RESP. All outputs are registered. `stall_o` = (state != IDLE).
- IDLE, valid_i, no memory op: bundle registered; wb_data_o = alu_result_i; stays in IDLE.
- IDLE, valid_i with memread_i or memwrite_i: capture address, data, funct3, rd and regwrite; go to REQ. If both ops are set, memread_i wins.
- REQ: dmem_req_o = 1, with addr = {addr[31:2],2'b00}, we and be stable until gnt.
  - On gnt for a store: complete and return to IDLE.
  - On gnt for a load: go to RESP.
- RESP: wait for dmem_rvalid_i, then complete and return to IDLE.
- Store lanes:
  - SB (000): be = 0001 << a[1:0]; wdata = {4{b}}.
  - SH (001): be = 0011 << a[1:0]; wdata = {2{h}}.
  - SW (010): be = 1111.
- Load extraction: select the byte/half indicated by a[1:0]. LB 000 / LH 001 sign-extend; LBU 100 / LHU 101 zero-extend; LW 010 uses the full word.
- Completion: one-cycle pulse on wb_valid_o. regwrite_o = captured regwrite, forced to 0 for stores and faults.
- Timeout: the counter clears on entry to REQ and to RESP. If DMEM_TIMEOUT cycles pass without gnt/rvalid, drop dmem_req_o, pulse wb_valid_o with bus_err_o = 1 and regwrite_o = 0, and return to IDLE.
- dmem_rvalid_i outside RESP is ignored.

## Timing
- Reset: state IDLE, counter 0. Every output is 0, including stall_o, dmem_req_o, dmem_we_o, dmem_be_o, wb_valid_o, wb_data_o, write_reg_o, regwrite_o, misaligned_o and bus_err_o.
- Non-memory op: wb_valid_o in cycle N+1. Back-to-back throughput is 1 per cycle.
- Load accepted in cycle N with zero-wait memory: req in N+1 (gnt), rvalid in N+2, wb_valid_o in N+3. stall_o is high in N+1 and N+2.
- Store with zero-wait grant: wb_valid_o in N+2.
- Upstream advances on the accept edge, then holds the next instruction while stall_o = 1.
- Reset mid-access: dmem_req_o drops at that edge and any later response is ignored.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access is LH/LHU/SH with a[0] = 1, or LW/SW with a[1:0] ≠ 0.
  - Such an access issues no bus request. It completes in IDLE-to-IDLE with wb_valid_o at N+1, misaligned_o = 1 and regwrite_o = 0.
- MISALIGN_TRAP_EN undefined: offending low address bits are treated as 0 (natural alignment), the access proceeds normally, and misaligned_o is tied to 0.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF, zero wait -> wb_valid_o at N+3, wb_data_o = 0xDEADBEEF, regwrite_o = 1.
- LB at 0x103, word 0x80AABBCC -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102, data 0x1234 -> dmem_be_o = 1100, dmem_wdata_o = 0x12341234, addr 0x100, regwrite_o = 0.
- LW with gnt delayed 3 cycles -> dmem_req_o held with stable addr; stall_o high throughout; upstream instruction not lost.
- DMEM_TIMEOUT = 4, gnt never asserted -> after 4 REQ cycles, bus_err_o = 1, regwrite_o = 0, back to IDLE.
- LW at 0x102 -> with MISALIGN_TRAP_EN: no req, misaligned_o = 1. Without it: access to 0x100 with misaligned_o = 0.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: PSRV32 memory-access stage. Issues loads/stores over a req/gnt/rvalid port and
// presents a registered MEM/WB bundle. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module mem_access #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data2_i,
  input  logic [4:0]  write_reg_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  funct3_i,
  input  logic        regwrite_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  write_reg_o,
  output logic        regwrite_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       off_reg, off_next;
  logic [2:0]       f3_reg, f3_next;
  logic             load_reg, load_next;
  logic             rw_reg, rw_next;

  logic        stall_reg, stall_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] daddr_reg, daddr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic        wbv_reg, wbv_next;
  logic [31:0] wbd_reg, wbd_next;
  logic [4:0]  wreg_reg, wreg_next;
  logic        rwo_reg, rwo_next;
  logic        mis_reg, mis_next;
  logic        berr_reg, berr_next;

  // Lane offset after natural alignment: halves drop a[0], words drop both bits.
  function automatic logic [1:0] lane_off(input logic [1:0] a, input logic [1:0] size);
    logic [1:0] off;
    case (size)
      2'b00:   off = a;
      2'b01:   off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  logic        mem_op;
  logic        mis_in;
  logic [1:0]  in_off;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  assign mem_op = memread_i | memwrite_i;
  assign in_off = lane_off(alu_result_i[1:0], funct3_i[1:0]);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis_in = 1'b0;
    case (funct3_i[1:0])
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = alu_result_i[0];
      default: mis_in = |alu_result_i[1:0];
    endcase
  end
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   in_be = 4'b0001 << in_off;
      2'b01:   in_be = 4'b0011 << in_off;
      default: in_be = 4'b1111;
    endcase
  end

  // Write data replicated across lanes so the byte enables alone pick the target bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign in_wdata[8*gi +: 8] = (funct3_i[1:0] == 2'b00) ? read_data2_i[7:0] :
                                   (funct3_i[1:0] == 2'b01) ? read_data2_i[8*(gi%2) +: 8] :
                                                              read_data2_i[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = dmem_rdata_i[{off_reg, 3'b000} +: 8];
    ld_half = off_reg[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_reg[1:0])
      2'b00:   ld_val = f3_reg[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = f3_reg[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    off_next   = off_reg;
    f3_next    = f3_reg;
    load_next  = load_reg;
    rw_next    = rw_reg;
    we_next    = we_reg;
    daddr_next = daddr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    wbv_next   = 1'b0;
    wbd_next   = wbd_reg;
    wreg_next  = wreg_reg;
    rwo_next   = rwo_reg;
    mis_next   = mis_reg;
    berr_next  = berr_reg;

    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          wreg_next = write_reg_i;
          mis_next  = 1'b0;
          berr_next = 1'b0;
          if (!mem_op) begin
            wbv_next = 1'b1;
            wbd_next = alu_result_i;
            rwo_next = regwrite_i;
          end else if (mis_in) begin
            wbv_next = 1'b1;
            wbd_next = alu_result_i;
            rwo_next = 1'b0;
            mis_next = 1'b1;
          end else begin
            state_next = REQ;
            cnt_next   = '0;
            off_next   = in_off;
            f3_next    = funct3_i;
            load_next  = memread_i;
            rw_next    = regwrite_i;
            we_next    = ~memread_i;
            daddr_next = {alu_result_i[31:2], 2'b00};
            wdata_next = in_wdata;
            be_next    = in_be;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          cnt_next = '0;
          if (load_reg) begin
            state_next = RESP;
          end else begin
            state_next = IDLE;
            wbv_next   = 1'b1;
            rwo_next   = 1'b0;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          wbv_next   = 1'b1;
          rwo_next   = 1'b0;
          berr_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          state_next = IDLE;
          wbv_next   = 1'b1;
          wbd_next   = ld_val;
          rwo_next   = rw_reg;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          wbv_next   = 1'b1;
          rwo_next   = 1'b0;
          berr_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    req_next   = (state_next == REQ);
    stall_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      off_reg   <= '0;
      f3_reg    <= '0;
      load_reg  <= 1'b0;
      rw_reg    <= 1'b0;
      stall_reg <= 1'b0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      daddr_reg <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      wbv_reg   <= 1'b0;
      wbd_reg   <= '0;
      wreg_reg  <= '0;
      rwo_reg   <= 1'b0;
      mis_reg   <= 1'b0;
      berr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      off_reg   <= off_next;
      f3_reg    <= f3_next;
      load_reg  <= load_next;
      rw_reg    <= rw_next;
      stall_reg <= stall_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      daddr_reg <= daddr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      wbv_reg   <= wbv_next;
      wbd_reg   <= wbd_next;
      wreg_reg  <= wreg_next;
      rwo_reg   <= rwo_next;
      mis_reg   <= mis_next;
      berr_reg  <= berr_next;
    end
  end

  assign stall_o      = stall_reg;
  assign dmem_req_o   = req_reg;
  assign dmem_we_o    = we_reg;
  assign dmem_addr_o  = daddr_reg;
  assign dmem_wdata_o = wdata_reg;
  assign dmem_be_o    = be_reg;
  assign wb_valid_o   = wbv_reg;
  assign wb_data_o    = wbd_reg;
  assign write_reg_o  = wreg_reg;
  assign regwrite_o   = rwo_reg;
  assign misaligned_o = mis_reg;
  assign bus_err_o    = berr_reg;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: randomized instruction stream and memory timing checked every cycle
// against a transaction-level model, plus directed literal cases.
`timescale 1ns/1ps
module tb_mem_access;
  localparam int T = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, valid_i, memread_i, memwrite_i, regwrite_i;
  logic [31:0] alu_result_i, read_data2_i, dmem_rdata_i;
  logic [4:0]  write_reg_i;
  logic [2:0]  funct3_i;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic        stall_o, dmem_req_o, dmem_we_o, wb_valid_o, regwrite_o, misaligned_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  write_reg_o;

  mem_access #(.DMEM_TIMEOUT(T)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .read_data2_i(read_data2_i), .write_reg_i(write_reg_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .funct3_i(funct3_i), .regwrite_i(regwrite_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_data_o(wb_data_o), .write_reg_o(write_reg_o), .regwrite_o(regwrite_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    bit          rw;
    bit          mis;
    bit          berr;
  } exp_t;
  exp_t expq[$];

  logic [31:0] mmem [64];
  logic [31:0] pmem [64];
  logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  bit          plan_mem = 0, plan_load = 0;
  int          plan_n = 0, plan_d = 0, plan_r = 0, plan_wb = 0;
  logic [5:0]  plan_idx = '0;
  logic [31:0] plan_addr = '0, plan_wdata = '0;
  logic [3:0]  plan_be = '0;
  int          stall_lo = 1, stall_hi = 0, req_lo = 1, req_hi = 0;
  bit          chk_en = 0, manual = 0, man_rvalid = 0;
  logic [31:0] man_rdata = '0;

  logic [31:0] last_wb_data = '0, last_gnt_wdata = '0, last_gnt_addr = '0;
  logic [3:0]  last_gnt_be = '0;
  int          last_wb_cyc = 0;
  bit          last_rw = 0, last_mis = 0, last_berr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_mis(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] v;
    int sh;
    if (f3[1:0] == 2'b00) begin
      sh = 8 * int'(a);
      v = (w >> sh) & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'b01) begin
      sh = 16 * (int'(a) / 2);
      v = (w >> sh) & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    int v;
    if (f3[1:0] == 2'b00) v = 1 << int'(a);
    else if (f3[1:0] == 2'b01) v = 3 << (2 * (int'(a) / 2));
    else v = 15;
    return 4'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {4{d[7:0]}};
    if (f3[1:0] == 2'b01) return {2{d[15:0]}};
    return d;
  endfunction

  // Transaction-level prediction made at the accepting edge of cycle n.
  task automatic accept(input int n, input bit mr, input bit mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input bit rw, input int d, input int r);
    exp_t e;
    logic [3:0] be;
    e.cyc = n + 1; e.data = '0; e.chk_data = 0; e.rd = rd; e.rw = 0; e.mis = 0; e.berr = 0;
    plan_mem = 0;
    if (!(mr || mw)) begin
      e.data = a; e.chk_data = 1; e.rw = rw;
    end else if (TRAP && is_mis(f3, a[1:0])) begin
      e.mis = 1;
    end else begin
      plan_mem = 1; plan_load = mr; plan_n = n; plan_d = d; plan_r = r;
      plan_idx = a[7:2]; plan_addr = {a[31:2], 2'b00};
      be = model_be(f3, a[1:0]);
      plan_be = be; plan_wdata = model_wdata(f3, wd);
      if (d >= T) begin
        e.cyc = n + 1 + T; e.berr = 1;
      end else if (!mr) begin
        e.cyc = n + 2 + d;
        for (int i = 0; i < 4; i++)
          if (be[i]) mmem[plan_idx][8*i +: 8] = plan_wdata[8*i +: 8];
      end else if (r >= T) begin
        e.cyc = n + 2 + d + T; e.berr = 1;
      end else begin
        e.cyc = n + 3 + d + r; e.chk_data = 1; e.rw = rw;
        e.data = load_val(mmem[plan_idx], a[1:0], f3);
      end
      plan_wb = e.cyc;
      stall_lo = n + 1; stall_hi = e.cyc - 1;
      req_lo = n + 1; req_hi = n + 1 + ((d < T) ? d : T - 1);
    end
    expq.push_back(e);
  endtask

  task automatic issue(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input bit rw,
                       input int d, input int r, output int acc);
    int guard = 0;
    @(negedge clk);
    valid_i = 1; memread_i = mr; memwrite_i = mw; funct3_i = f3; alu_result_i = a;
    read_data2_i = wd; write_reg_i = rd; regwrite_i = rw;
    while (stall_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: stall_o=%b held for %0d cycles, required release", stall_o, guard);
      acc = -1;
      valid_i = 0;
    end else begin
      acc = cyc;
      accept(cyc, mr, mw, f3, a, wd, rd, rw, d, r);
    end
  endtask

  task automatic bubble();
    @(negedge clk);
    valid_i = 0; memread_i = $urandom_range(0, 1); memwrite_i = $urandom_range(0, 1);
    alu_result_i = $urandom; funct3_i = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    valid_i = 0;
    while (expq.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: %0d completions outstanding, required 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  // Memory responder: timing comes from the plan chosen at acceptance.
  always @(negedge clk) begin
    dmem_gnt_i = 0;
    dmem_rvalid_i = 0;
    dmem_rdata_i = $urandom;
    if (manual) begin
      dmem_rvalid_i = man_rvalid;
      dmem_rdata_i = man_rdata;
    end else begin
      if (plan_mem && plan_d < T && cyc == plan_n + 1 + plan_d) begin
        dmem_gnt_i = 1;
        last_gnt_be = dmem_be_o; last_gnt_wdata = dmem_wdata_o; last_gnt_addr = dmem_addr_o;
        if (dmem_req_o && dmem_we_o)
          for (int i = 0; i < 4; i++)
            if (dmem_be_o[i]) pmem[dmem_addr_o[7:2]][8*i +: 8] = dmem_wdata_o[8*i +: 8];
      end
      if (plan_mem && plan_load && plan_d < T && plan_r < T && cyc == plan_n + 2 + plan_d + plan_r) begin
        dmem_rvalid_i = 1;
        dmem_rdata_i = pmem[plan_idx];
      end else if (!(plan_mem && plan_load && cyc >= plan_n + 2 + plan_d && cyc < plan_wb) &&
                   $urandom_range(0, 7) == 0) begin
        dmem_rvalid_i = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ew, er;
      exp_t e;
      ew = (expq.size() > 0) && (expq[0].cyc == cyc);
      er = (cyc >= req_lo) && (cyc <= req_hi);
      check("wb_valid", wb_valid_o, ew);
      check("stall", stall_o, (cyc >= stall_lo) && (cyc <= stall_hi));
      check("dmem_req", dmem_req_o, er);
      if (er && dmem_req_o) begin
        check("dmem_addr", dmem_addr_o, plan_addr);
        check("dmem_we", dmem_we_o, !plan_load);
        if (!plan_load) begin
          check("dmem_be", dmem_be_o, plan_be);
          check("dmem_wdata", dmem_wdata_o, plan_wdata);
        end
      end
      if (ew) begin
        e = expq.pop_front();
        if (wb_valid_o) begin
          check("write_reg", write_reg_o, e.rd);
          check("regwrite", regwrite_o, e.rw);
          check("misaligned", misaligned_o, e.mis);
          check("bus_err", bus_err_o, e.berr);
          if (e.chk_data) check("wb_data", wb_data_o, e.data);
          last_wb_data = wb_data_o; last_wb_cyc = cyc; last_rw = regwrite_o;
          last_mis = misaligned_o; last_berr = bus_err_o;
          $display("txn cyc=%0d rd=%0d data=%h rw=%0b mis=%0b berr=%0b",
                   cyc, write_reg_o, wb_data_o, regwrite_o, misaligned_o, bus_err_o);
        end
      end
    end
  end

  initial begin
    int acc;
    bit mr, mw;
    logic [2:0] f3;
    int kind, d, r;

    reset_i = 0; valid_i = 0; memread_i = 0; memwrite_i = 0; regwrite_i = 0;
    alu_result_i = '0; read_data2_i = '0; write_reg_i = '0; funct3_i = '0;
    for (int i = 0; i < 64; i++) begin
      mmem[i] = $urandom;
      pmem[i] = mmem[i];
    end

    repeat (3) @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_req", dmem_req_o, 0);
    check("rst_we", dmem_we_o, 0);
    check("rst_be", dmem_be_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_wdata", dmem_wdata_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_write_reg", write_reg_o, 0);
    check("rst_regwrite", regwrite_o, 0);
    check("rst_misaligned", misaligned_o, 0);
    check("rst_bus_err", bus_err_o, 0);
    reset_i = 1;
    chk_en = 1;

    // Pin the model itself with hand-computed values.
    check("model_lb", load_val(32'h80AABBCC, 2'd3, 3'b000), 32'hFFFFFF80);
    check("model_lbu", load_val(32'h80AABBCC, 2'd3, 3'b100), 32'h00000080);
    check("model_sh_be", model_be(3'b001, 2'd2), 4'b1100);

    mmem[0] = 32'hDEADBEEF; pmem[0] = 32'hDEADBEEF;
    issue(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 1, 0, 0, acc);
    drain();
    check("lw_data", last_wb_data, 32'hDEADBEEF);
    check("lw_latency", last_wb_cyc - acc, 3);
    check("lw_regwrite", last_rw, 1);

    mmem[0] = 32'h80AABBCC; pmem[0] = 32'h80AABBCC;
    issue(1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 0, 0, acc);
    drain();
    check("lb_data", last_wb_data, 32'hFFFFFF80);
    issue(1, 0, 3'b100, 32'h103, 32'h0, 5'd6, 1, 0, 0, acc);
    drain();
    check("lbu_data", last_wb_data, 32'h00000080);

    issue(0, 1, 3'b001, 32'h102, 32'h00001234, 5'd7, 1, 0, 0, acc);
    drain();
    check("sh_be", last_gnt_be, 4'b1100);
    check("sh_wdata", last_gnt_wdata, 32'h12341234);
    check("sh_addr", last_gnt_addr, 32'h100);
    check("sh_regwrite", last_rw, 0);
    check("sh_latency", last_wb_cyc - acc, 2);
    issue(1, 0, 3'b010, 32'h100, 32'h0, 5'd8, 1, 0, 0, acc);
    drain();
    check("sh_readback", last_wb_data, 32'h1234BBCC);

    issue(1, 0, 3'b010, 32'h104, 32'h0, 5'd9, 1, 3, 0, acc);
    issue(0, 0, 3'b000, 32'hCAFE0001, 32'h0, 5'd10, 1, 0, 0, acc);
    drain();
    check("held_instr_data", last_wb_data, 32'hCAFE0001);

    issue(1, 0, 3'b010, 32'h108, 32'h0, 5'd11, 1, T, 0, acc);
    drain();
    check("timeout_berr", last_berr, 1);
    check("timeout_regwrite", last_rw, 0);
    check("timeout_latency", last_wb_cyc - acc, T + 1);

    issue(1, 0, 3'b010, 32'h102, 32'h0, 5'd12, 1, 0, 0, acc);
    drain();
`ifdef MISALIGN_TRAP_EN
    check("mis_flag", last_mis, 1);
    check("mis_latency", last_wb_cyc - acc, 1);
    check("mis_regwrite", last_rw, 0);
`else
    check("mis_flag", last_mis, 0);
    check("mis_latency", last_wb_cyc - acc, 3);
    check("mis_data", last_wb_data, 32'h1234BBCC);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) bubble();
      kind = $urandom_range(0, 9);
      mr = (kind >= 3 && kind < 6) || kind == 9;
      mw = kind >= 6;
      if (mr) f3 = ld_f3[$urandom_range(0, 4)];
      else if (mw) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 2);
      r = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 2);
      issue(mr, mw, f3, 32'h100 + $urandom_range(0, 255), $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), d, r, acc);
    end
    drain();

    // Reset in the middle of an access: request drops, later response is ignored.
    chk_en = 0;
    manual = 1;
    issue(1, 0, 3'b010, 32'h110, 32'h0, 5'd13, 1, T, 0, acc);
    @(negedge clk);
    valid_i = 0;
    @(negedge clk);
    check("pre_reset_req", dmem_req_o, 1);
    reset_i = 0;
    @(negedge clk);
    check("mid_reset_req", dmem_req_o, 0);
    check("mid_reset_stall", stall_o, 0);
    check("mid_reset_wb_valid", wb_valid_o, 0);
    reset_i = 1;
    man_rvalid = 1; man_rdata = 32'h5555AAAA;
    @(negedge clk);
    man_rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_wb_valid", wb_valid_o, 0);
      check("post_reset_stall", stall_o, 0);
    end
    expq.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
